// File: rtl/lcd_scanout.sv
// LCD scanout engine: fetches RGB565 word pairs from a framebuffer into a
// small pixel FIFO and presents them to a pop-driven panel interface.
module lcd_scanout #(
  parameter int WIDTH   = 480,
  parameter int HEIGHT  = 320,
  parameter int DEPTH   = 16,
  parameter int NF_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [23:0] fb_base,
  output logic [23:0] mem_addr,
  output logic        mem_ren,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        lcdvm_next_pixel,
  output logic        lcdvm_newfield,
  output logic        lcdvm_wait,
  output logic [7:0]  lcdvm_red,
  output logic [7:0]  lcdvm_green,
  output logic [7:0]  lcdvm_blue,
  output logic        frame_done
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int NWORD = NPIX / 2;
  localparam int PW    = $clog2(NPIX);
  localparam int WW    = $clog2(NWORD + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int AW1   = AW + 1;
  localparam int HW    = (NF_HOLD > 1) ? $clog2(NF_HOLD) : 1;

  localparam logic [PW-1:0]  LAST  = PW'(NPIX - 1);
  localparam logic [WW-1:0]  WMAX  = WW'(NWORD);
  localparam logic [HW-1:0]  HLOAD = HW'(NF_HOLD - 1);
  localparam logic [AW1-1:0] FULLC = AW1'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NEWFIELD,
    S_RUN
  } state_t;

  state_t         r_state;
  logic [15:0]    r_fifo [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW1-1:0] r_cnt;
  logic [PW-1:0]  r_pix;
  logic [WW-1:0]  r_words;
  logic [23:0]    r_base;
  logic [HW-1:0]  r_hold;
  logic           r_ren;
  logic [23:0]    r_addr;

  logic           w_empty;
  logic           w_pop;
  logic           w_last;
  logic           w_push;
  logic           w_start;
  logic           w_enter;
  logic           w_flush;
  logic [15:0]    w_pix;

  assign w_empty = (r_cnt == '0);
  assign w_pop   = (r_state == S_RUN) && ena
                && lcdvm_next_pixel && !w_empty;
  assign w_last  = w_pop && (r_pix == LAST);
  // Responses arriving in IDLE belong to an abandoned request.
  assign w_push  = r_ren && mem_ready && ena
                && (r_state != S_IDLE);
  assign w_start = ena && (r_state != S_IDLE) && !r_ren
                && ((FULLC - r_cnt) >= AW1'(2))
                && (r_words < WMAX);
  assign w_enter = ena && (((r_state == S_IDLE) && !r_ren)
                || w_last);
  assign w_flush = !ena || (r_state == S_IDLE) || w_last;

  assign w_pix = w_empty ? 16'h0000 : r_fifo[r_rptr];

  assign mem_ren        = r_ren;
  assign mem_addr       = r_addr;
  assign lcdvm_newfield = (r_state == S_NEWFIELD);
  assign lcdvm_wait     = (r_state != S_RUN) || w_empty;
  assign lcdvm_red      = {w_pix[15:11], w_pix[15:13]};
  assign lcdvm_green    = {w_pix[10:5], w_pix[10:9]};
  assign lcdvm_blue     = {w_pix[4:0], w_pix[4:2]};
  assign frame_done     = w_last;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr]          <= mem_rdata[15:0];
      r_fifo[r_wptr + AW'(1)] <= mem_rdata[31:16];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_pix   <= '0;
      r_words <= '0;
      r_base  <= '0;
      r_hold  <= '0;
      r_ren   <= 1'b0;
      r_addr  <= '0;
    end else begin
      if (w_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(2);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        r_cnt <= r_cnt
               + (w_push ? AW1'(2) : AW1'(0))
               - (w_pop ? AW1'(1) : AW1'(0));
      end

      if (r_ren) begin
        if (mem_ready) r_ren <= 1'b0;
      end else if (w_start) begin
        r_ren  <= 1'b1;
        r_addr <= r_base + 24'(r_words);
      end

      if (w_enter)     r_words <= '0;
      else if (w_push) r_words <= r_words + WW'(1);

      if (w_enter)    r_pix <= '0;
      else if (w_pop) r_pix <= r_pix + PW'(1);

      if (!ena) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (!r_ren) begin
              r_state <= S_NEWFIELD;
              r_base  <= fb_base;
              r_hold  <= HLOAD;
            end
          end
          S_NEWFIELD: begin
            if (r_hold == '0) r_state <= S_RUN;
            else r_hold <= r_hold - HW'(1);
          end
          S_RUN: begin
            if (w_last) begin
              r_state <= S_NEWFIELD;
              r_base  <= fb_base;
              r_hold  <= HLOAD;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Free-space gating on fetch start must make a full-FIFO push impossible.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      assert (int'(r_cnt) + 2 - int'(w_pop) <= DEPTH);
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed/random bench for lcd_scanout with a queue-based pixel model
// and a variable-latency framebuffer memory.
module tb_lcd_scanout;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int D     = 4;
  localparam int NFH   = 8;
  localparam int NPIX  = W * H;
  localparam int NWORD = NPIX / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [23:0] fb_base;
  logic [23:0] mem_addr;
  logic        mem_ren;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        next_pixel;
  logic        nf;
  logic        wt;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        fd;

  always #5 clk = ~clk;

  lcd_scanout #(
    .WIDTH(W), .HEIGHT(H), .DEPTH(D), .NF_HOLD(NFH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .fb_base(fb_base),
    .mem_addr(mem_addr),
    .mem_ren(mem_ren),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .lcdvm_next_pixel(next_pixel),
    .lcdvm_newfield(nf),
    .lcdvm_wait(wt),
    .lcdvm_red(red),
    .lcdvm_green(green),
    .lcdvm_blue(blue),
    .frame_done(fd)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [1024];
  logic [15:0] pq [$];

  int          lat = 2;
  bit          pend = 0;
  int          pcnt = 0;
  logic [23:0] paddr = '0;
  int          exp_word = 0;
  int          pops = 0;
  int          pushes_frame = 0;
  int          nf_run = 0;
  int          frames = 0;
  bit          prev_nf = 0;
  bit          expect_nf = 0;
  bit          stale = 0;
  bit          run = 0;
  logic [23:0] cur_base = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-replication expansion written as plain arithmetic.
  function automatic logic [23:0] expand(input logic [15:0] p);
    int c5r;
    int c6;
    int c5b;
    c5r = int'(p) >> 11;
    c6  = (int'(p) >> 5) & 63;
    c5b = int'(p) & 31;
    return {8'((c5r << 3) | (c5r >> 2)),
            8'((c6 << 2) | (c6 >> 4)),
            8'((c5b << 3) | (c5b >> 2))};
  endfunction

  task automatic observe();
    logic [23:0] rgb;
    bit          pop;
    bit          exp_fd;
    rgb = {red, green, blue};
    pop = ena && next_pixel && !wt;

    if (expect_nf) begin
      chk("nf_after_done", {31'd0, nf}, 1);
      expect_nf = 0;
    end
    if (nf && !prev_nf) begin
      cur_base     = fb_base;
      exp_word     = 0;
      pops         = 0;
      pushes_frame = 0;
      run          = 0;
    end
    if (nf) begin
      nf_run++;
      chk("nf_wait", {31'd0, wt}, 1);
    end else if (nf_run > 0) begin
      chk("nf_len", nf_run, NFH);
      nf_run = 0;
      run    = 1;
    end
    if (stale) chk("idle_while_stale", {31'd0, nf}, 0);

    if (pq.size() == 0) chk("rgb_empty", {8'd0, rgb}, 0);
    if (run) chk("wait_empty", {31'd0, wt}, (pq.size() == 0) ? 1 : 0);
    else     chk("wait_high", {31'd0, wt}, 1);
    if (!wt && pq.size() > 0) begin
      chk("rgb_head", {8'd0, rgb}, {8'd0, expand(pq[0])});
      if (pq[0] == 16'hF800) chk("red_pixel", {8'd0, rgb}, 32'h00FF0000);
      if (pq[0] == 16'h001F) chk("blue_pixel", {8'd0, rgb}, 32'h000000FF);
    end

    exp_fd = pop && (pops == NPIX - 1);
    chk("frame_done", {31'd0, fd}, {31'd0, exp_fd});
    if (pop) begin
      pops++;
      if (pq.size() > 0) void'(pq.pop_front());
      if (exp_fd) begin
        expect_nf = 1;
        frames++;
      end
    end

    if (pend) begin
      chk("ren_held", {31'd0, mem_ren}, 1);
      chk("addr_held", {8'd0, mem_addr}, {8'd0, paddr});
    end
    if (mem_ready) begin
      if (stale || !ena) begin
        stale = 0;
      end else begin
        pq.push_back(mem_rdata[15:0]);
        pq.push_back(mem_rdata[31:16]);
        pushes_frame++;
        chk("no_overflow", (pq.size() <= D) ? 1 : 0, 1);
      end
    end
    if (!ena) begin
      pq.delete();
      run    = 0;
      nf_run = 0;
      if (pend && !mem_ready) stale = 1;
    end
    prev_nf = nf;
  endtask

  task automatic drive_mem();
    if (mem_ready) begin
      mem_ready = 0;
      mem_rdata = $urandom;
      pend      = 0;
    end else if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        mem_ready = 1;
        mem_rdata = mem[paddr[9:0]];
      end
    end else if (mem_ren) begin
      pend  = 1;
      pcnt  = lat;
      paddr = mem_addr;
      chk("fetch_addr", {8'd0, mem_addr}, 32'(cur_base) + 32'(exp_word));
      chk("fetch_limit", (exp_word < NWORD) ? 1 : 0, 1);
      exp_word++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  initial begin
    int f0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[256]   = 32'h001FF800;
    rst        = 1;
    ena        = 0;
    next_pixel = 0;
    mem_ready  = 0;
    mem_rdata  = '0;
    fb_base    = 24'h000100;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ren", {31'd0, mem_ren}, 0);
    chk("rst_addr", {8'd0, mem_addr}, 0);
    chk("rst_nf", {31'd0, nf}, 0);
    chk("rst_wait", {31'd0, wt}, 1);
    chk("rst_rgb", {8'd0, red, green, blue}, 0);
    chk("rst_fd", {31'd0, fd}, 0);
    @(posedge clk);
    #1;
    rst        = 0;
    ena        = 1;
    next_pixel = 1;

    // First frame: consumer pops every cycle, latency 2.
    for (int i = 0; i < 400 && frames < 1; i++) cycle();
    chk("frame1_reached", (frames >= 1) ? 1 : 0, 1);

    // Random consumer and memory latency across several frames.
    for (int i = 0; i < 1500 && frames < 4; i++) begin
      next_pixel = 1'($urandom_range(0, 1));
      lat        = $urandom_range(1, 4);
      cycle();
    end
    chk("frames_random", (frames >= 4) ? 1 : 0, 1);

    // Consumer stalls: only DEPTH/2 words may be fetched.
    next_pixel = 0;
    ena        = 0;
    for (int i = 0; i < 20 && (pend || stale || i < 2); i++) cycle();
    fb_base = 24'h000200;
    ena     = 1;
    lat     = 2;
    repeat (60) cycle();
    chk("nopop_words", pushes_frame, 2);
    chk("nopop_ren_idle", {31'd0, mem_ren}, 0);

    // Drop enable with a request outstanding, re-enable before it returns.
    next_pixel = 1;
    lat        = 5;
    for (int i = 0; i < 40 && !pend; i++) cycle();
    chk("pend_seen", {31'd0, pend}, 1);
    next_pixel = 0;
    ena        = 0;
    cycle();
    cycle();
    chk("drop_ren_held", {31'd0, mem_ren}, 1);
    fb_base    = 24'h000300;
    ena        = 1;
    next_pixel = 1;
    lat        = 2;
    f0 = frames;
    for (int i = 0; i < 600 && frames == f0; i++) cycle();
    chk("reenable_frame", (frames > f0) ? 1 : 0, 1);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
